// File: rtl/ultrasonic_multi_ranger.sv
// ultrasonic_multi_ranger
//   Round-robin controller for CH_NUM ultrasonic sensors. For each channel in
//   turn it pulses Trig, waits for the echo, times the echo width in
//   microseconds, converts it to millimetres and hands the result to a
//   valid/ready stream. A missing or over-long echo produces a timeout result.
//
// Ports
//   CLK_50M    in   system clock
//   RST        in   asynchronous active-low reset
//   en         in   1 = keep ranging; 0 = finish current channel, then idle
//   Echo       in   [CH_NUM]  asynchronous echo inputs, bit i = channel i
//   Trig       out  [CH_NUM]  trigger outputs, at most one bit high
//   dist_data  out  [DATA_W]  distance in mm, all-ones on timeout/saturation
//   dist_ch    out  [CH_W]    channel the result belongs to
//   dist_tout  out  1 = result is a timeout
//   dist_valid out  result valid
//   dist_ready in   consumer accepts when valid & ready at posedge
module ultrasonic_multi_ranger #(
  parameter int CH_NUM     = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GUARD_US   = 60000,
  parameter int DATA_W     = 16,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              CLK_50M,
  input  logic              RST,
  input  logic              en,
  input  logic [CH_NUM-1:0] Echo,
  output logic [CH_NUM-1:0] Trig,
  output logic [DATA_W-1:0] dist_data,
  output logic [CH_W-1:0]   dist_ch,
  output logic              dist_tout,
  output logic              dist_valid,
  input  logic              dist_ready
);

  localparam int CYC_US  = CLK_HZ / 1_000_000;
  localparam int T_MAX0  = (TIMEOUT_US > GUARD_US) ? TIMEOUT_US : GUARD_US;
  localparam int T_MAX   = (T_MAX0 > TRIG_US) ? T_MAX0 : TRIG_US;
  localparam int TIMER_W = $clog2(T_MAX + 1);
  localparam int PRESC_W = $clog2(CYC_US);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYC_US - 1);
  localparam logic [TIMER_W-1:0] TRIG_LAST  = TIMER_W'(TRIG_US - 1);
  localparam logic [TIMER_W-1:0] TOUT_LAST  = TIMER_W'(TIMEOUT_US - 1);
  localparam logic [TIMER_W-1:0] GUARD_LAST = TIMER_W'(GUARD_US - 1);
  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(CH_NUM - 1);
  // 0.1715 mm/us in Q16 (sound round trip at ~343 m/s)
  localparam logic [31:0]        MM_PER_US_Q16 = 32'd11239;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_CALC, S_TOUT, S_OUT, S_GUARD
  } state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic [PRESC_W-1:0]  presc_reg, presc_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [TIMER_W-1:0]  echo_us_reg, echo_us_next;
  logic [DATA_W-1:0]   dist_data_reg, dist_data_next;
  logic [CH_W-1:0]     dist_ch_reg, dist_ch_next;
  logic                dist_tout_reg, dist_tout_next;
  logic                dist_valid_reg, dist_valid_next;
  logic [CH_NUM-1:0]   trig_reg, trig_next;
  logic [CH_NUM-1:0]   sync1_reg, echo_s_reg;
  logic [CH_NUM-1:0]   ch_onehot;
  logic                echo_cur, us_tick, counting;
  logic [31:0]         prod, dist_full;
  logic                dist_sat;

  // Two-flop synchronisers on every echo input
  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      sync1_reg  <= '0;
      echo_s_reg <= '0;
    end else begin
      sync1_reg  <= Echo;
      echo_s_reg <= sync1_reg;
    end
  end

  // One-hot decode of the channel about to be triggered
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_onehot
      assign ch_onehot[gi] = (ch_next == CH_W'(gi));
    end
  endgenerate

  assign echo_cur = echo_s_reg[ch_reg];
  assign us_tick  = (presc_reg == PRESC_LAST);
  assign counting = (state_reg == S_TRIG) || (state_reg == S_WAIT_RISE) ||
                    (state_reg == S_MEASURE) || (state_reg == S_GUARD);

  assign prod      = 32'(echo_us_reg) * MM_PER_US_Q16;
  assign dist_full = prod >> 16;
  assign dist_sat  = |(dist_full >> DATA_W);

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    presc_next     = presc_reg;
    timer_next     = timer_reg;
    echo_us_next   = echo_us_reg;
    dist_data_next = dist_data_reg;
    dist_ch_next   = dist_ch_reg;
    dist_tout_next = dist_tout_reg;

    case (state_reg)
      S_IDLE:      if (en) state_next = S_TRIG;
      S_TRIG:      if (us_tick && timer_reg == TRIG_LAST) state_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (echo_cur)                                 state_next = S_MEASURE;
        else if (us_tick && timer_reg == TOUT_LAST)   state_next = S_TOUT;
      end
      S_MEASURE: begin
        // The timer is cleared on leaving, so keep a copy for CALC
        echo_us_next = timer_reg;
        if (!echo_cur)                                state_next = S_CALC;
        else if (us_tick && timer_reg == TOUT_LAST)   state_next = S_TOUT;
      end
      S_CALC: begin
        dist_data_next = dist_sat ? '1 : dist_full[DATA_W-1:0];
        dist_ch_next   = ch_reg;
        dist_tout_next = 1'b0;
        state_next     = S_OUT;
      end
      S_TOUT: begin
        dist_data_next = '1;
        dist_ch_next   = ch_reg;
        dist_tout_next = 1'b1;
        state_next     = S_OUT;
      end
      S_OUT: begin
        if (dist_valid_reg && dist_ready) begin
          state_next = S_GUARD;
          ch_next    = (ch_reg == CH_LAST) ? '0 : ch_reg + 1'b1;
        end
      end
      S_GUARD: begin
        if (us_tick && timer_reg == GUARD_LAST)
          state_next = en ? S_TRIG : S_IDLE;
      end
      default:     state_next = S_IDLE;
    endcase

    // Timebase restarts on every state change. MEASURE is entered on the
    // cycle the rise is seen, which already belongs to the pulse, so the
    // prescaler starts at 1 there to make echo_us = floor(high cycles/CYC_US).
    if (state_next != state_reg) begin
      presc_next = (state_next == S_MEASURE) ? PRESC_W'(1) : '0;
      timer_next = '0;
    end else if (counting) begin
      presc_next = us_tick ? '0 : presc_reg + 1'b1;
      if (us_tick) timer_next = timer_reg + 1'b1;
    end

    // Valid follows OUT by one cycle and drops the cycle after acceptance
    dist_valid_next = (state_reg == S_OUT) && !(dist_valid_reg && dist_ready);
    trig_next       = (state_next == S_TRIG) ? ch_onehot : '0;
  end

  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      state_reg      <= S_IDLE;
      ch_reg         <= '0;
      presc_reg      <= '0;
      timer_reg      <= '0;
      echo_us_reg    <= '0;
      dist_data_reg  <= '0;
      dist_ch_reg    <= '0;
      dist_tout_reg  <= 1'b0;
      dist_valid_reg <= 1'b0;
      trig_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      ch_reg         <= ch_next;
      presc_reg      <= presc_next;
      timer_reg      <= timer_next;
      echo_us_reg    <= echo_us_next;
      dist_data_reg  <= dist_data_next;
      dist_ch_reg    <= dist_ch_next;
      dist_tout_reg  <= dist_tout_next;
      dist_valid_reg <= dist_valid_next;
      trig_reg       <= trig_next;
    end
  end

  assign Trig       = trig_reg;
  assign dist_data  = dist_data_reg;
  assign dist_ch    = dist_ch_reg;
  assign dist_tout  = dist_tout_reg;
  assign dist_valid = dist_valid_reg;

endmodule
